line_window_2x2: RTL and testbench
==================================

Name: line_window_2x2

Overview:
- Reader-side companion to the line-delay buffers in the interpolation datapath.
- Consumes a raster pixel stream and keeps one internal line buffer.
- Emits a registered 2x2 neighbourhood (upper-left, upper-right, lower-left, lower-right) with pixel coordinates, used as the input window for bilinear interpolation.
- Uses valid/ready handshakes on both sides, so it sits between the pixel source (DMA/VDMA unpack) and the interpolation kernel.

Parameters:
- IMG_W, 640, pixels per line (>= 2)
- IMG_H, 480, lines per frame (>= 2)
- DW, 8, pixel data width
- XW, 10, x coordinate width (2**XW >= IMG_W)
- YW, 10, y coordinate width (2**YW >= IMG_H)

Ports:
- CLK  in  1  clock; all logic on rising edge
- RSTN  in  1  synchronous reset, active low
- S_VALID  in  1  input pixel valid
- S_READY  out  1  block can accept a pixel
- S_DATA  in  DW  input pixel
- S_SOF  in  1  start of frame; qualifies S_DATA as pixel (0,0)
- M_VALID  out  1  window valid
- M_READY  in  1  downstream accepts window
- P00  out  DW  pixel (x-1, y-1)
- P01  out  DW  pixel (x, y-1)
- P10  out  DW  pixel (x-1, y)
- P11  out  DW  pixel (x, y)
- M_X  out  XW  x of P11
- M_Y  out  YW  y of P11
- M_EOL  out  1  window is last of its line (x = IMG_W-1)
- M_EOF  out  1  window is last of frame (x = IMG_W-1 and y = IMG_H-1)

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-low (RSTN).
- Reset values: M_VALID=0, all data/coordinate outputs=0, M_EOL=M_EOF=0, internal x/y counters=0. S_READY=1 after reset.
- Line buffer contents are not cleared by reset; they are never observable before being rewritten, because row 0 produces no windows.
- Accept: a pixel is accepted on a cycle with S_VALID && S_READY.
- S_READY = !M_VALID || M_READY (combinational), so the block holds at most one window.
- Position: the accepted pixel takes position (x,y) from the counters. If S_SOF=1 on an accepted beat, the position is forced to (0,0) and counters resync from there.
- Counters after each accept: x++. At x = IMG_W-1, x wraps to 0 and y++. At y = IMG_H-1 and x = IMG_W-1, both wrap to 0.
- Line buffer: IMG_W entries, indexed by x, read-before-write. On accept at column x, the old entry is pixel (x, y-1) and the new entry is S_DATA.
  - Read data must be available in the accept cycle. A BRAM implementation prefetches the read address (next x) one cycle early; a distributed RAM implementation may read combinationally. The external timing below is identical either way.
- Column registers: previous-pixel-of-row and previous-pixel-of-upper-row, updated on every accept. They are not reset at x=0; they are ignored there.
- Output: if the accepted pixel has x>=1 and y>=1, then on the next cycle M_VALID=1 with:
  - P00=(x-1,y-1), P01=(x,y-1), P10=(x-1,y), P11=(x,y)
  - M_X=x, M_Y=y, M_EOL and M_EOF as defined in Ports.
- Latency: exactly 1 cycle from accept to M_VALID.
- Pixels with x=0 or y=0 are stored but produce no window. A full frame yields (IMG_W-1)*(IMG_H-1) windows.
- Backpressure: while M_VALID && !M_READY, all M_* outputs and P* hold stable and S_READY=0. M_VALID drops the cycle after M_READY=1, unless a new qualifying pixel was accepted in the same cycle (back-to-back throughput of 1 window/cycle).
- Input gaps (S_VALID=0) insert bubbles only; counters and buffers hold.
- Reset mid-frame:
  - M_VALID drops the next cycle.
  - Counters return to 0; the next accepted pixel is (0,0) regardless of S_SOF.
  - The window in flight is discarded.
- S_SOF mid-line or mid-frame: the position is forced to (0,0) and no window is produced for that pixel. Line buffer contents from the aborted frame are overwritten as row 0 proceeds.

Test Plan:
- IMG_W=4, IMG_H=3, continuous ramp S_DATA=16*y+x, M_READY=1 -> exactly 6 windows. First window (1,1): P00=0x00, P01=0x01, P10=0x10, P11=0x11, one cycle after the (1,1) accept. Last window (3,2): P00=0x12, P01=0x13, P10=0x22, P11=0x23, M_EOL=1, M_EOF=1.
- Same stream with M_READY low for 3 cycles at window (2,1) -> S_READY=0 and outputs frozen at P11=0x12 for those 3 cycles. No pixel lost; the remaining 4 windows are correct and in order.
- Random S_VALID gaps (~50%) over 2 back-to-back frames -> 12 windows total, identical values to the gap-free run. M_X/M_Y wrap from (3,2) to (1,1) between frames.
- Assert S_SOF on pixel (2,1) of frame 1 with the ramp restarting at 0x00 -> no window for that pixel. The next windows use counters restarted at (0,0), the first appearing at (1,1) with P11=0x11.
- RSTN low for 1 cycle mid-frame while M_VALID=1 -> M_VALID=0 and outputs=0 the following cycle. The next accepted pixel is treated as (0,0), and the next full frame yields 6 correct windows.
- IMG_W=2, IMG_H=2 -> exactly 1 window per frame, with M_EOL=M_EOF=1 and P00..P11=0x00,0x01,0x10,0x11.

Source files
------------

// File: rtl/line_window_2x2.sv
// 2x2 neighbourhood generator for bilinear interpolation: one line buffer plus
// column registers turn a raster pixel stream into registered windows with coordinates.
module line_window_2x2 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic [DW-1:0] S_DATA,
    input  logic          S_SOF,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic [DW-1:0] P00,
    output logic [DW-1:0] P01,
    output logic [DW-1:0] P10,
    output logic [DW-1:0] P11,
    output logic [XW-1:0] M_X,
    output logic [YW-1:0] M_Y,
    output logic          M_EOL,
    output logic          M_EOF
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] x_reg;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_reg;
    logic [YW-1:0] y_next;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic [XW-1:0] rd_addr;
    logic          accept;
    logic          qualify;

    logic [DW-1:0] line_mem [IMG_W];
    logic [DW-1:0] rd_data_reg;
    logic [DW-1:0] prev_reg;
    logic [DW-1:0] prev_up_reg;

    // The block holds at most one window; a new one may enter as the old one leaves.
    assign S_READY = !M_VALID || M_READY;
    assign accept  = S_VALID && S_READY && RSTN;

    always_comb begin
        pos_x   = S_SOF ? '0 : x_reg;
        pos_y   = S_SOF ? '0 : y_reg;
        x_next  = x_reg;
        y_next  = y_reg;
        qualify = accept && (pos_x != '0) && (pos_y != '0);
        if (accept) begin
            if (pos_x == X_LAST) begin
                x_next = '0;
                y_next = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
            end else begin
                x_next = pos_x + XW'(1);
                y_next = pos_y;
            end
        end
        // Prefetch the column the next beat will land on; it never equals the
        // column being written, so the registered read sees the upper-row pixel.
        rd_addr = RSTN ? x_next : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    // Line buffer and column registers carry no reset: row 0 and column 0 never emit.
    always_ff @(posedge CLK) begin
        if (accept) begin
            line_mem[pos_x] <= S_DATA;
            prev_reg        <= S_DATA;
            prev_up_reg     <= rd_data_reg;
        end
        rd_data_reg <= line_mem[rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            M_VALID <= 1'b0;
            P00     <= '0;
            P01     <= '0;
            P10     <= '0;
            P11     <= '0;
            M_X     <= '0;
            M_Y     <= '0;
            M_EOL   <= 1'b0;
            M_EOF   <= 1'b0;
        end else if (qualify) begin
            M_VALID <= 1'b1;
            P00     <= prev_up_reg;
            P01     <= rd_data_reg;
            P10     <= prev_reg;
            P11     <= S_DATA;
            M_X     <= pos_x;
            M_Y     <= pos_y;
            M_EOL   <= (pos_x == X_LAST);
            M_EOF   <= (pos_x == X_LAST) && (pos_y == Y_LAST);
        end else if (M_READY) begin
            M_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_window_2x2.sv
// Directed bench for line_window_2x2: a 4x3 instance for ramp, backpressure, gaps,
// SOF resync and mid-frame reset, plus a 2x2 instance for the minimum geometry.
module tb_line_window_2x2;

    typedef struct packed {
        logic [7:0] p00;
        logic [7:0] p01;
        logic [7:0] p10;
        logic [7:0] p11;
        logic [9:0] x;
        logic [9:0] y;
        logic       eol;
        logic       eof;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       s_valid_a, s_ready_a, s_sof_a, m_valid_a, m_ready_a, eol_a, eof_a;
    logic [7:0] s_data_a, p00_a, p01_a, p10_a, p11_a;
    logic [9:0] mx_a, my_a;
    logic       s_valid_b, s_ready_b, s_sof_b, m_valid_b, m_ready_b, eol_b, eof_b;
    logic [7:0] s_data_b, p00_b, p01_b, p10_b, p11_b;
    logic [9:0] mx_b, my_b;

    int   checks = 0;
    int   errors = 0;
    win_t q_a[$];
    win_t q_b[$];
    win_t exp_q[$];

    line_window_2x2 #(.IMG_W(4), .IMG_H(3), .DW(8), .XW(10), .YW(10)) dut_a (
        .CLK(clk), .RSTN(rstn),
        .S_VALID(s_valid_a), .S_READY(s_ready_a), .S_DATA(s_data_a), .S_SOF(s_sof_a),
        .M_VALID(m_valid_a), .M_READY(m_ready_a),
        .P00(p00_a), .P01(p01_a), .P10(p10_a), .P11(p11_a),
        .M_X(mx_a), .M_Y(my_a), .M_EOL(eol_a), .M_EOF(eof_a)
    );

    line_window_2x2 #(.IMG_W(2), .IMG_H(2), .DW(8), .XW(10), .YW(10)) dut_b (
        .CLK(clk), .RSTN(rstn),
        .S_VALID(s_valid_b), .S_READY(s_ready_b), .S_DATA(s_data_b), .S_SOF(s_sof_b),
        .M_VALID(m_valid_b), .M_READY(m_ready_b),
        .P00(p00_b), .P01(p01_b), .P10(p10_b), .P11(p11_b),
        .M_X(mx_b), .M_Y(my_b), .M_EOL(eol_b), .M_EOF(eof_b)
    );

    // Collect every window that completes a handshake on the following edge.
    always @(negedge clk) begin
        if (rstn && m_valid_a && m_ready_a)
            q_a.push_back({p00_a, p01_a, p10_a, p11_a, mx_a, my_a, eol_a, eof_a});
        if (rstn && m_valid_b && m_ready_b)
            q_b.push_back({p00_b, p01_b, p10_b, p11_b, mx_b, my_b, eol_b, eof_b});
    end

    function automatic win_t exp_win(int x, int y, int w, int h);
        win_t e;
        e.p00 = 8'(16 * (y - 1) + x - 1);
        e.p01 = 8'(16 * (y - 1) + x);
        e.p10 = 8'(16 * y + x - 1);
        e.p11 = 8'(16 * y + x);
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.eol = (x == w - 1);
        e.eof = (x == w - 1) && (y == h - 1);
        return e;
    endfunction

    task automatic push_frame_exp(input int w, input int h);
        for (int y = 1; y < h; y++)
            for (int x = 1; x < w; x++)
                exp_q.push_back(exp_win(x, y, w, h));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic sof);
        bit ok = 1'b0;
        int n = 0;
        s_valid_a = 1'b1;
        s_data_a  = d;
        s_sof_a   = sof;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_ready_a;
            next_cycle();
            n++;
        end
        s_valid_a = 1'b0;
        s_sof_a   = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_a_timeout got no accept want accept for data %h", d);
        end
    endtask

    task automatic send_b(input logic [7:0] d, input logic sof);
        bit ok = 1'b0;
        int n = 0;
        s_valid_b = 1'b1;
        s_data_b  = d;
        s_sof_b   = sof;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_ready_b;
            next_cycle();
            n++;
        end
        s_valid_b = 1'b0;
        s_sof_b   = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_b_timeout got no accept want accept for data %h", d);
        end
    endtask

    // Pixel index i of a 4x3 ramp frame.
    function automatic logic [7:0] ramp(int i);
        return 8'(16 * (i / 4) + (i % 4));
    endfunction

    task automatic send_range(input int first, input int last, input bit sof_first, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) next_cycle();
            send_a(ramp(i), sof_first && (i == first));
        end
    endtask

    task automatic drain();
        repeat (3) next_cycle();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b/%b want 0/0", m_valid_a, m_valid_b);
        end
        checks++;
        if ({p00_a, p01_a, p10_a, p11_a, mx_a, my_a, eol_a, eof_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h %h %h %h %0d %0d %b %b want all 0",
                     p00_a, p01_a, p10_a, p11_a, mx_a, my_a, eol_a, eof_a);
        end
        checks++;
        if (s_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", s_ready_a);
        end
        next_cycle();
    endtask

    task automatic test_ramp();
        q_a.delete();
        exp_q.delete();
        send_range(0, 4, 1'b1, 1'b0);
        checks++;
        if (m_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL ramp_no_early_window got %b want 0", m_valid_a);
        end
        send_a(8'h11, 1'b0);
        checks++;
        if (m_valid_a !== 1'b1 || {p00_a, p01_a, p10_a, p11_a} !== 32'h00011011 ||
            mx_a !== 10'd1 || my_a !== 10'd1) begin
            errors++;
            $display("FAIL ramp_first_window got v=%b %h %h %h %h (%0d,%0d) want v=1 00 01 10 11 (1,1)",
                     m_valid_a, p00_a, p01_a, p10_a, p11_a, mx_a, my_a);
        end
        send_range(6, 11, 1'b0, 1'b0);
        drain();
        push_frame_exp(4, 3);
        checks++;
        if (q_a.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ramp_count got %0d want %0d", q_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
            checks++;
            if (q_a[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ramp_win%0d got %h want %h", i, q_a[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        q_a.delete();
        exp_q.delete();
        send_range(0, 6, 1'b1, 1'b0);
        m_ready_a = 1'b0;
        s_valid_a = 1'b1;
        s_data_a  = 8'h13;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (s_ready_a !== 1'b0 || m_valid_a !== 1'b1 || p11_a !== 8'h12 ||
                p00_a !== 8'h01 || mx_a !== 10'd2 || my_a !== 10'd1) begin
                errors++;
                $display("FAIL bp_hold%0d got rdy=%b v=%b p00=%h p11=%h (%0d,%0d) want rdy=0 v=1 p00=01 p11=12 (2,1)",
                         k, s_ready_a, m_valid_a, p00_a, p11_a, mx_a, my_a);
            end
            next_cycle();
        end
        s_valid_a = 1'b0;
        m_ready_a = 1'b1;
        send_range(7, 11, 1'b0, 1'b0);
        drain();
        push_frame_exp(4, 3);
        checks++;
        if (q_a.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count got %0d want %0d", q_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
            checks++;
            if (q_a[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_win%0d got %h want %h", i, q_a[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gaps();
        q_a.delete();
        exp_q.delete();
        send_range(0, 11, 1'b1, 1'b1);
        send_range(0, 11, 1'b0, 1'b1);
        drain();
        push_frame_exp(4, 3);
        push_frame_exp(4, 3);
        checks++;
        if (q_a.size() != exp_q.size()) begin
            errors++;
            $display("FAIL gaps_count got %0d want %0d", q_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
            checks++;
            if (q_a[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL gaps_win%0d got %h want %h", i, q_a[i], exp_q[i]);
            end
        end
        if (q_a.size() >= 7) begin
            checks++;
            if (q_a[5].x !== 10'd3 || q_a[5].y !== 10'd2 || q_a[6].x !== 10'd1 || q_a[6].y !== 10'd1) begin
                errors++;
                $display("FAIL gaps_wrap got (%0d,%0d)->(%0d,%0d) want (3,2)->(1,1)",
                         q_a[5].x, q_a[5].y, q_a[6].x, q_a[6].y);
            end
        end
    endtask

    task automatic test_sof();
        q_a.delete();
        exp_q.delete();
        send_range(0, 5, 1'b1, 1'b0);
        send_range(0, 11, 1'b1, 1'b0);
        drain();
        exp_q.push_back(exp_win(1, 1, 4, 3));
        push_frame_exp(4, 3);
        checks++;
        if (q_a.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sof_count got %0d want %0d", q_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
            checks++;
            if (q_a[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sof_win%0d got %h want %h", i, q_a[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_midreset();
        q_a.delete();
        exp_q.delete();
        send_range(0, 5, 1'b1, 1'b0);
        m_ready_a = 1'b0;
        checks++;
        if (m_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_valid got %b want 1", m_valid_a);
        end
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
        checks++;
        if (m_valid_a !== 1'b0 || {p00_a, p01_a, p10_a, p11_a, mx_a, my_a, eol_a, eof_a} !== '0 ||
            s_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_post got v=%b %h %h %h %h (%0d,%0d) rdy=%b want v=0 all 0 rdy=1",
                     m_valid_a, p00_a, p01_a, p10_a, p11_a, mx_a, my_a, s_ready_a);
        end
        m_ready_a = 1'b1;
        q_a.delete();
        send_range(0, 11, 1'b0, 1'b0);
        drain();
        push_frame_exp(4, 3);
        checks++;
        if (q_a.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_count got %0d want %0d", q_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
            checks++;
            if (q_a[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_win%0d got %h want %h", i, q_a[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_small();
        logic [7:0] pix [4];
        pix[0] = 8'h00;
        pix[1] = 8'h01;
        pix[2] = 8'h10;
        pix[3] = 8'h11;
        q_b.delete();
        exp_q.delete();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++)
                send_b(pix[i], (f == 0) && (i == 0));
        drain();
        push_frame_exp(2, 2);
        push_frame_exp(2, 2);
        checks++;
        if (q_b.size() != exp_q.size()) begin
            errors++;
            $display("FAIL small_count got %0d want %0d", q_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_b.size(); i++) begin
            checks++;
            if (q_b[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL small_win%0d got %h want %h", i, q_b[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rstn      = 1'b0;
        s_valid_a = 1'b0; s_sof_a = 1'b0; s_data_a = 8'h00; m_ready_a = 1'b1;
        s_valid_b = 1'b0; s_sof_b = 1'b0; s_data_b = 8'h00; m_ready_b = 1'b1;
        test_reset();
        test_ramp();
        test_backpressure();
        test_gaps();
        test_sof();
        test_midreset();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
